time_coeff_engine: RTL and testbench

//  Table-driven generator for the time-dependent coefficients (scale * dt^p) used by the Kalman predict stage.

---
 rtl/time_coeff_engine.sv | 261 ++++++++++++++++++++++++++
 tb/tb_time_coeff_engine.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_coeff_engine.sv
// Generates scale[i] * dt^pow[i] for a programmable table using one shared, tagged
// FP64 multiplier; results land in a shadow bank and are swapped into coef_out at the end.
module time_coeff_engine #(
  parameter int DWIDTH    = 64,
  parameter int MAX_POW   = 6,
  parameter int NUM_COEF  = 16,
  parameter int MAX_OUTST = 4,
  parameter int TAG_W     = $clog2(NUM_COEF + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DWIDTH-1:0]             delta_t,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_COEF)-1:0]   cfg_idx,
  input  logic [$clog2(MAX_POW+1)-1:0]  cfg_pow,
  input  logic [DWIDTH-1:0]             cfg_scale,
  output logic                          mul_req_valid,
  input  logic                          mul_req_ready,
  output logic [DWIDTH-1:0]             mul_req_a,
  output logic [DWIDTH-1:0]             mul_req_b,
  output logic [TAG_W-1:0]              mul_req_tag,
  input  logic                          mul_resp_valid,
  output logic                          mul_resp_ready,
  input  logic [DWIDTH-1:0]             mul_resp_y,
  input  logic [TAG_W-1:0]              mul_resp_tag,
  output logic [NUM_COEF*DWIDTH-1:0]    coef_out,
  output logic                          busy,
  output logic                          done,
  output logic                          valid,
  output logic                          cfg_err,
  output logic                          tag_err
);

  localparam int IDX_W = $clog2(NUM_COEF);
  localparam int K_W   = $clog2(MAX_POW + 1);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int PW_N  = 1 << K_W;
  localparam logic [K_W-1:0]   K_FIRST = K_W'(2);
  localparam logic [K_W-1:0]   K_LAST  = K_W'(MAX_POW);
  localparam logic [K_W-1:0]   K_ONE   = K_W'(1);
  localparam logic [IDX_W-1:0] I_LAST  = IDX_W'(NUM_COEF - 1);
  localparam logic [IDX_W-1:0] I_ONE   = IDX_W'(1);
  localparam logic [OUT_W-1:0] O_MAX   = OUT_W'(MAX_OUTST);
  localparam logic [OUT_W-1:0] O_ONE   = OUT_W'(1);
  localparam logic [TAG_W-1:0] TAG_PW  = '1;
  localparam logic [TAG_W-1:0] TAG_NC  = TAG_W'(NUM_COEF);

  typedef enum logic [2:0] {
    IDLE, POW_REQ, POW_WAIT, SCL_ISSUE, SCL_DRAIN, SWAP, ABORT_DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [IDX_W-1:0]       i_q, i_d;
  logic [OUT_W-1:0]       outst_q, outst_d;
  logic                   pow_out_q, pow_out_d;
  logic                   valid_q, valid_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   tag_err_q, tag_err_d;
  logic [NUM_COEF-1:0]    pend_q, pend_d;
  logic [DWIDTH-1:0]      dt_q, dt_d;
  logic [DWIDTH-1:0]      pw_q     [PW_N];
  logic [DWIDTH-1:0]      pw_d     [PW_N];
  logic [K_W-1:0]         tpow_q   [NUM_COEF];
  logic [K_W-1:0]         tpow_d   [NUM_COEF];
  logic [DWIDTH-1:0]      tscl_q   [NUM_COEF];
  logic [DWIDTH-1:0]      tscl_d   [NUM_COEF];
  logic [DWIDTH-1:0]      shadow_q [NUM_COEF];
  logic [DWIDTH-1:0]      shadow_d [NUM_COEF];
  logic [DWIDTH-1:0]      active_q [NUM_COEF];
  logic [DWIDTH-1:0]      active_d [NUM_COEF];

  logic             req_fire, resp_fire, resp_pw_ok, resp_sc_ok, issue, retire, advance;
  logic [IDX_W-1:0] resp_idx;

  // Request mux: power chain in POW_REQ, table entry i in SCL_ISSUE.
  always_comb begin
    mul_req_valid = 1'b0;
    mul_req_a     = pw_q[tpow_q[i_q]];
    mul_req_b     = tscl_q[i_q];
    mul_req_tag   = TAG_W'(i_q);
    if (state_q == POW_REQ) begin
      mul_req_valid = 1'b1;
      mul_req_a     = pw_q[k_q - K_ONE];
      mul_req_b     = dt_q;
      mul_req_tag   = TAG_PW;
    end else if (state_q == SCL_ISSUE) begin
      mul_req_valid = (tpow_q[i_q] != '0) && (outst_q < O_MAX);
    end
  end

  assign mul_resp_ready = (state_q != IDLE);
  assign req_fire       = mul_req_valid && mul_req_ready;
  assign resp_fire      = mul_resp_valid && mul_resp_ready;
  assign resp_idx       = mul_resp_tag[IDX_W-1:0];
  assign resp_pw_ok     = (mul_resp_tag == TAG_PW) && pow_out_q;
  assign resp_sc_ok     = (mul_resp_tag != TAG_PW) && (mul_resp_tag < TAG_NC) && pend_q[resp_idx];
  assign issue          = req_fire && (state_q == SCL_ISSUE);
  assign retire         = resp_fire && resp_sc_ok;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    i_d       = i_q;
    pow_out_d = pow_out_q;
    valid_d   = valid_q;
    cfg_err_d = 1'b0;
    tag_err_d = 1'b0;
    pend_d    = pend_q;
    dt_d      = dt_q;
    pw_d      = pw_q;
    tpow_d    = tpow_q;
    tscl_d    = tscl_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    advance   = 1'b0;

    if (cfg_we) begin
      if (state_q == IDLE) begin
        tpow_d[cfg_idx] = cfg_pow;
        tscl_d[cfg_idx] = cfg_scale;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    // Responses are retired here; ABORT_DRAIN retires without storing the product.
    if (resp_fire) begin
      if (resp_pw_ok) begin
        pow_out_d = 1'b0;
        if (state_q == POW_WAIT) pw_d[k_q] = mul_resp_y;
      end else if (resp_sc_ok) begin
        pend_d[resp_idx] = 1'b0;
        if (state_q != ABORT_DRAIN) shadow_d[resp_idx] = mul_resp_y;
      end else begin
        tag_err_d = 1'b1;
      end
    end

    if (issue) pend_d[i_q] = 1'b1;

    case ({issue, retire})
      2'b10:   outst_d = outst_q + O_ONE;
      2'b01:   outst_d = outst_q - O_ONE;
      default: outst_d = outst_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          dt_d    = delta_t;
          pw_d[1] = delta_t;
          k_d     = K_FIRST;
          state_d = POW_REQ;
        end
      end
      POW_REQ: begin
        if (req_fire) begin
          pow_out_d = 1'b1;
          state_d   = POW_WAIT;
        end
      end
      POW_WAIT: begin
        if (resp_fire && resp_pw_ok) begin
          if (k_q == K_LAST) begin
            i_d     = '0;
            state_d = SCL_ISSUE;
          end else begin
            k_d     = k_q + K_ONE;
            state_d = POW_REQ;
          end
        end
      end
      SCL_ISSUE: begin
        if (tpow_q[i_q] == '0) begin
          shadow_d[i_q] = '0;
          advance       = 1'b1;
        end else begin
          advance = req_fire;
        end
        if (advance) begin
          if (i_q == I_LAST) state_d = SCL_DRAIN;
          else               i_d     = i_q + I_ONE;
        end
      end
      SCL_DRAIN: begin
        if (outst_q == '0) state_d = SWAP;
      end
      SWAP: begin
        active_d = shadow_q;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      ABORT_DRAIN: begin
        if ((outst_q == '0) && !pow_out_q) begin
          k_d     = K_FIRST;
          state_d = POW_REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A restart latches the new dt immediately and drains whatever is still in flight.
    if (start && (state_q != IDLE)) begin
      dt_d    = delta_t;
      pw_d[1] = delta_t;
      state_d = ABORT_DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      i_q       <= '0;
      outst_q   <= '0;
      pow_out_q <= 1'b0;
      valid_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      tag_err_q <= 1'b0;
      pend_q    <= '0;
      dt_q      <= '0;
      for (int n = 0; n < PW_N; n++) pw_q[n] <= '0;
      for (int n = 0; n < NUM_COEF; n++) begin
        tpow_q[n]   <= '0;
        tscl_q[n]   <= '0;
        shadow_q[n] <= '0;
        active_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      i_q       <= i_d;
      outst_q   <= outst_d;
      pow_out_q <= pow_out_d;
      valid_q   <= valid_d;
      cfg_err_q <= cfg_err_d;
      tag_err_q <= tag_err_d;
      pend_q    <= pend_d;
      dt_q      <= dt_d;
      pw_q      <= pw_d;
      tpow_q    <= tpow_d;
      tscl_q    <= tscl_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    coef_out = '0;
    for (int n = 0; n < NUM_COEF; n++) coef_out[n*DWIDTH +: DWIDTH] = active_q[n];
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == SWAP);
  assign valid   = valid_q;
  assign cfg_err = cfg_err_q;
  assign tag_err = tag_err_q;

endmodule

// File: tb/tb_time_coeff_engine.sv
// Directed bench for time_coeff_engine with a behavioural FP64 multiplier that can
// answer in order after a fixed latency or hold responses and return them reversed.
module tb_time_coeff_engine;

  localparam logic [4:0]  TAG_PW = 5'h1F;
  localparam logic [63:0] F0_25 = 64'h3FD0000000000000;
  localparam logic [63:0] F0_5  = 64'h3FE0000000000000;
  localparam logic [63:0] F1_0  = 64'h3FF0000000000000;
  localparam logic [63:0] F2_0  = 64'h4000000000000000;
  localparam logic [63:0] F3_0  = 64'h4008000000000000;
  localparam logic [63:0] F6_0  = 64'h4018000000000000;
  localparam logic [63:0] F16_0 = 64'h4030000000000000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [63:0]   delta_t = '0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_idx = '0;
  logic [2:0]    cfg_pow = '0;
  logic [63:0]   cfg_scale = '0;
  logic          mul_req_valid;
  logic          mul_req_ready = 1'b1;
  logic [63:0]   mul_req_a, mul_req_b;
  logic [4:0]    mul_req_tag;
  logic          mul_resp_valid = 1'b0;
  logic          mul_resp_ready;
  logic [63:0]   mul_resp_y = '0;
  logic [4:0]    mul_resp_tag = '0;
  logic [1023:0] coef_out;
  logic          busy, done, valid, cfg_err, tag_err;

  time_coeff_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .delta_t(delta_t),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pow(cfg_pow), .cfg_scale(cfg_scale),
    .mul_req_valid(mul_req_valid), .mul_req_ready(mul_req_ready),
    .mul_req_a(mul_req_a), .mul_req_b(mul_req_b), .mul_req_tag(mul_req_tag),
    .mul_resp_valid(mul_resp_valid), .mul_resp_ready(mul_resp_ready),
    .mul_resp_y(mul_resp_y), .mul_resp_tag(mul_resp_tag),
    .coef_out(coef_out), .busy(busy), .done(done), .valid(valid),
    .cfg_err(cfg_err), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Multiplier model and event counters, all owned by this one process.
  logic [63:0] q_y[$];
  logic [4:0]  q_tag[$];
  int          q_due[$];
  int cyc = 0, last_req = 0, lat = 3;
  int req_cnt = 0, scl_cnt = 0, inflight = 0, max_if = 0;
  int done_cnt = 0, cfg_err_cnt = 0, tag_err_cnt = 0;
  int inj_req = 0, inj_done = 0;
  bit rev_mode = 1'b0;

  always @(negedge clk) begin
    mul_resp_valid = 1'b0;
    if (!rst_n) begin
      q_y.delete(); q_tag.delete(); q_due.delete();
      inflight = 0;
    end else begin
      cyc++;
      done_cnt    += int'(done);
      cfg_err_cnt += int'(cfg_err);
      tag_err_cnt += int'(tag_err);
      if (mul_req_valid && mul_req_ready) begin
        q_y.push_back($realtobits($bitstoreal(mul_req_a) * $bitstoreal(mul_req_b)));
        q_tag.push_back(mul_req_tag);
        q_due.push_back(cyc + lat);
        req_cnt++;
        last_req = cyc;
        if (mul_req_tag != TAG_PW) begin
          scl_cnt++;
          inflight++;
        end
      end
      if (mul_resp_ready) begin
        if (inj_req != inj_done) begin
          mul_resp_valid = 1'b1;
          mul_resp_tag   = 5'd15;
          mul_resp_y     = 64'h4059000000000000;
          inj_done++;
        end else if (q_y.size() > 0) begin
          if (rev_mode && (cyc >= last_req + 10)) begin
            mul_resp_valid = 1'b1;
            mul_resp_y     = q_y.pop_back();
            mul_resp_tag   = q_tag.pop_back();
            void'(q_due.pop_back());
          end else if (!rev_mode && (q_due[0] <= cyc)) begin
            mul_resp_valid = 1'b1;
            mul_resp_y     = q_y.pop_front();
            mul_resp_tag   = q_tag.pop_front();
            void'(q_due.pop_front());
          end
          if (mul_resp_valid && (mul_resp_tag != TAG_PW)) inflight--;
        end
      end
      if (!rev_mode) max_if = 0;
      else if (inflight > max_if) max_if = inflight;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input int pw, input logic [63:0] scl);
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_pow = 3'(pw); cfg_scale = scl;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input logic [63:0] dt);
    start = 1'b1; delta_t = dt;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [63:0] coef(input int i);
    return coef_out[i*64 +: 64];
  endfunction

  function automatic logic [63:0] t3_exp(input int i);
    real e = real'(i + 1);
    for (int n = 0; n < (i % 6) + 1; n++) e = e * 2.0;
    return $realtobits(e);
  endfunction

  initial begin
    bit ok;
    int r0, c0, t0, d0, s0;

    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_done", done, 0);
    check("rst_req_valid", mul_req_valid, 0);
    check("rst_resp_ready", mul_resp_ready, 0);
    check("rst_coef_zero", coef_out == '0, 1);

    // T2: dt=2.0, e0 = 0.5*dt^2, e1 = 0.25*dt^6
    cfg_write(0, 2, F0_5);
    cfg_write(1, 6, F0_25);
    r0 = req_cnt;
    do_start(F2_0);
    check("t2_busy", busy, 1);
    wait_done(300, ok);
    check("t2_done_seen", ok, 1);
    tick();
    check("t2_done_pulse", done, 0);
    check("t2_req_count", req_cnt - r0, 7);
    check("t2_coef0", coef(0), F2_0);
    check("t2_coef1", coef(1), F16_0);
    check("t2_coef2", coef(2), 0);
    check("t2_coef15", coef(15), 0);
    check("t2_valid", valid, 1);
    check("t2_busy_end", busy, 0);

    // T5/T6: cfg write while busy is rejected; stray tag 15 is flagged and discarded
    c0 = cfg_err_cnt;
    t0 = tag_err_cnt;
    do_start(F2_0);
    tick();
    cfg_write(2, 2, F1_0);
    tick();
    check("t5_cfg_err", cfg_err_cnt - c0, 1);
    inj_req++;
    tick(); tick();
    check("t6_tag_err", tag_err_cnt - t0, 1);
    check("t6_coef15_held", coef(15), 0);
    check("t6_coef0_held", coef(0), F2_0);
    wait_done(300, ok);
    check("t5_done_seen", ok, 1);
    tick();
    check("t5_coef2_unchanged", coef(2), 0);
    check("t5_coef1", coef(1), F16_0);
    check("t6_coef15_final", coef(15), 0);
    cfg_write(2, 1, F3_0);
    tick();
    check("t5_idle_no_err", cfg_err_cnt - c0, 1);
    do_start(F2_0);
    wait_done(300, ok);
    check("t5_done2_seen", ok, 1);
    tick();
    check("t5_coef2_new", coef(2), F6_0);

    // T3: all entries enabled, reversed late responses
    for (int i = 0; i < 16; i++) cfg_write(i, (i % 6) + 1, $realtobits(real'(i + 1)));
    t0 = tag_err_cnt;
    rev_mode = 1'b1;
    do_start(F2_0);
    wait_done(3000, ok);
    check("t3_done_seen", ok, 1);
    tick();
    check("t3_max_inflight", max_if, 4);
    rev_mode = 1'b0;
    for (int i = 0; i < 16; i++) check($sformatf("t3_coef%0d", i), coef(i), t3_exp(i));
    check("t3_no_tag_err", tag_err_cnt - t0, 0);

    // T4: restart two cycles into the scale phase with dt=1.0
    t0 = tag_err_cnt;
    do_start(F2_0);
    s0 = scl_cnt;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (scl_cnt != s0) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4_scale_seen", ok, 1);
    tick();
    d0 = done_cnt;
    do_start(F1_0);
    tick();
    check("t4_valid_held", valid, 1);
    check("t4_busy", busy, 1);
    check("t4_coef5_held", coef(5), t3_exp(5));
    wait_done(400, ok);
    check("t4_done_seen", ok, 1);
    repeat (3) tick();
    check("t4_single_done", done_cnt - d0, 1);
    for (int i = 0; i < 16; i++)
      check($sformatf("t4_coef%0d", i), coef(i), $realtobits(real'(i + 1)));
    check("t4_no_tag_err", tag_err_cnt - t0, 0);

    // T1: reset mid-run clears outputs and table
    do_start(F2_0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("t1_busy", busy, 0);
    check("t1_valid", valid, 0);
    check("t1_req_valid", mul_req_valid, 0);
    check("t1_coef_zero", coef_out == '0, 1);
    tick();
    rst_n = 1'b1;
    tick();
    r0 = req_cnt;
    do_start(F2_0);
    wait_done(300, ok);
    check("t1_done_seen", ok, 1);
    tick();
    check("t1_req_count", req_cnt - r0, 5);
    check("t1_table_cleared", coef_out == '0, 1);
    check("t1_valid_after", valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
